// File: rtl/wash_pkg.sv
// Shared types, codes and per-program lookups for the wash cycle sequencer.
package wash_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FILL        = 4'd1,
    ST_WASH        = 4'd2,
    ST_DRAIN       = 4'd3,
    ST_RINSE_FILL  = 4'd4,
    ST_RINSE       = 4'd5,
    ST_RINSE_DRAIN = 4'd6,
    ST_SPIN        = 4'd7,
    ST_DONE        = 4'd8,
    ST_PAUSE       = 4'd9,
    ST_ERROR       = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    MOTOR_OFF     = 2'b00,
    MOTOR_AGITATE = 2'b01,
    MOTOR_SPIN    = 2'b10
  } motor_e;

  typedef enum logic [1:0] {
    PROG_QUICK  = 2'b00,
    PROG_NORMAL = 2'b01,
    PROG_HEAVY  = 2'b10,
    PROG_ALT    = 2'b11
  } prog_e;

  localparam logic [1:0] LEVEL_EMPTY = 2'd0;
  localparam logic [1:0] LEVEL_LOW   = 2'd1;
  localparam logic [1:0] LEVEL_MID   = 2'd2;
  localparam logic [1:0] LEVEL_FULL  = 2'd3;

  typedef struct packed {
    logic   fill_valve;
    logic   drain_pump;
    motor_e motor;
    logic   door_lock;
    logic   done;
    logic   error;
  } act_t;

  function automatic logic [1:0] target_level(input logic [1:0] p);
    case (p)
      PROG_QUICK: return LEVEL_LOW;
      PROG_HEAVY: return LEVEL_FULL;
      default:    return LEVEL_MID;
    endcase
  endfunction

  function automatic logic [1:0] rinse_passes(input logic [1:0] p);
    case (p)
      PROG_HEAVY: return 2'd2;
      default:    return 2'd1;
    endcase
  endfunction

  function automatic act_t decode_outputs(input state_e s);
    act_t a;
    a = '0;
    case (s)
      ST_FILL, ST_RINSE_FILL: begin
        a.fill_valve = 1'b1;
        a.door_lock  = 1'b1;
      end
      ST_WASH, ST_RINSE: begin
        a.motor     = MOTOR_AGITATE;
        a.door_lock = 1'b1;
      end
      ST_DRAIN, ST_RINSE_DRAIN: begin
        a.drain_pump = 1'b1;
        a.door_lock  = 1'b1;
      end
      ST_SPIN: begin
        a.drain_pump = 1'b1;
        a.motor      = MOTOR_SPIN;
        a.door_lock  = 1'b1;
      end
      ST_DONE:  a.done  = 1'b1;
      ST_ERROR: a.error = 1'b1;
      default:  a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Phase timer: clear / hold / load (pause restore) / increment, with limit compare.
module wash_phase_timer #(
  parameter int unsigned TW = 10
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [TW-1:0] load_val_i,
  input  logic [TW-1:0] limit_i,
  output logic [TW-1:0] count_o,
  output logic          at_limit_o
);

  logic [TW-1:0] count_q, count_d;

  // Restore beats clear so a resume lands on the saved count.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + TW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == limit_i);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Wash program sequencer: FSM walking fill/wash/drain/rinse/spin with door pause
// and fill/drain timeouts; actuator outputs registered from the next state.
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned TW          = 10,
  parameter int unsigned FILL_TICKS  = 8,
  parameter int unsigned WASH_TICKS  = 20,
  parameter int unsigned DRAIN_TICKS = 6,
  parameter int unsigned RINSE_TICKS = 10,
  parameter int unsigned SPIN_TICKS  = 12
) (
  input  logic       clkorig,
  input  logic       power,
  input  logic       start,
  input  logic       door,
  input  logic [1:0] prog,
  input  logic [1:0] water_level,
  output logic       fill_valve,
  output logic       drain_pump,
  output logic [1:0] motor,
  output logic       door_lock,
  output logic [3:0] state,
  output logic       done,
  output logic       error
);

  localparam logic [TW-1:0] FILL_LIM    = TW'(FILL_TICKS - 1);
  localparam logic [TW-1:0] DRAIN_LIM   = TW'(DRAIN_TICKS - 1);
  localparam logic [TW-1:0] RINSE_LIM   = TW'(RINSE_TICKS - 1);
  localparam logic [TW-1:0] SPIN_LIM    = TW'(SPIN_TICKS - 1);
  localparam logic [TW-1:0] WASH_LIM_QK = TW'(WASH_TICKS - 1);
  localparam logic [TW-1:0] WASH_LIM_NM = TW'(2 * WASH_TICKS - 1);
  localparam logic [TW-1:0] WASH_LIM_HV = TW'(3 * WASH_TICKS - 1);

  state_e        state_q, state_d, saved_state_q, saved_state_d;
  logic [1:0]    prog_q, prog_d, rinse_cnt_q, rinse_cnt_d;
  logic [TW-1:0] saved_timer_q, saved_timer_d;
  logic [TW-1:0] tmr_count, tmr_limit;
  logic          tmr_clr, tmr_load, tmr_inc, tmr_at_limit;
  logic          in_cycle, level_ok, drained;
  act_t          act_q;

  assign in_cycle = (state_q >= ST_FILL) && (state_q <= ST_SPIN);
  assign level_ok = (water_level >= target_level(prog_q));
  assign drained  = (water_level == LEVEL_EMPTY);

  wash_phase_timer #(.TW(TW)) u_timer (
    .clk_i      (clkorig),
    .rst_n_i    (power),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .inc_i      (tmr_inc),
    .load_val_i (saved_timer_q),
    .limit_i    (tmr_limit),
    .count_o    (tmr_count),
    .at_limit_o (tmr_at_limit)
  );

  // Limit for the current phase; WASH scales with the latched program.
  always_comb begin
    tmr_limit = '0;
    case (state_q)
      ST_FILL, ST_RINSE_FILL:   tmr_limit = FILL_LIM;
      ST_DRAIN, ST_RINSE_DRAIN: tmr_limit = DRAIN_LIM;
      ST_RINSE:                 tmr_limit = RINSE_LIM;
      ST_SPIN:                  tmr_limit = SPIN_LIM;
      ST_WASH: begin
        case (prog_q)
          PROG_QUICK: tmr_limit = WASH_LIM_QK;
          PROG_HEAVY: tmr_limit = WASH_LIM_HV;
          default:    tmr_limit = WASH_LIM_NM;
        endcase
      end
      default:                  tmr_limit = '0;
    endcase
  end

  // Next-state logic; an open door during a locked phase outranks any phase exit.
  always_comb begin
    state_d       = state_q;
    prog_d        = prog_q;
    rinse_cnt_d   = rinse_cnt_q;
    saved_state_d = saved_state_q;
    saved_timer_d = saved_timer_q;
    tmr_clr       = 1'b0;
    tmr_load      = 1'b0;
    tmr_inc       = 1'b0;
    if (door && in_cycle) begin
      state_d       = ST_PAUSE;
      saved_state_d = state_q;
      saved_timer_d = tmr_count;
    end else begin
      tmr_inc = in_cycle;
      case (state_q)
        ST_IDLE: begin
          if (start && !door) begin
            state_d     = ST_FILL;
            prog_d      = prog;
            rinse_cnt_d = 2'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FILL, ST_RINSE_FILL: begin
          if (level_ok) begin
            if (state_q == ST_FILL) state_d = ST_WASH;
            else                    state_d = ST_RINSE;
          end else if (tmr_at_limit) begin
            state_d = ST_ERROR;
          end else begin
            state_d = state_q;
          end
        end
        ST_WASH: begin
          if (tmr_at_limit) state_d = ST_DRAIN;
          else              state_d = ST_WASH;
        end
        ST_RINSE: begin
          if (tmr_at_limit) state_d = ST_RINSE_DRAIN;
          else              state_d = ST_RINSE;
        end
        ST_DRAIN, ST_RINSE_DRAIN: begin
          if (drained) begin
            if (state_q == ST_DRAIN) begin
              state_d = ST_RINSE_FILL;
            end else if ((rinse_cnt_q + 2'd1) < rinse_passes(prog_q)) begin
              state_d     = ST_RINSE_FILL;
              rinse_cnt_d = rinse_cnt_q + 2'd1;
            end else begin
              state_d = ST_SPIN;
            end
          end else if (tmr_at_limit) begin
            state_d = ST_ERROR;
          end else begin
            state_d = state_q;
          end
        end
        ST_SPIN: begin
          if (tmr_at_limit) state_d = ST_DONE;
          else              state_d = ST_SPIN;
        end
        ST_DONE: begin
          if (door) state_d = ST_IDLE;
          else      state_d = ST_DONE;
        end
        ST_PAUSE: begin
          if (start && !door) begin
            state_d  = saved_state_q;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
      tmr_clr = (state_d != state_q);
    end
  end

  // State, context and actuator registers.
  always_ff @(posedge clkorig) begin
    if (!power) begin
      state_q       <= ST_IDLE;
      saved_state_q <= ST_IDLE;
      saved_timer_q <= '0;
      prog_q        <= 2'b00;
      rinse_cnt_q   <= 2'd0;
      act_q         <= '0;
    end else begin
      state_q       <= state_d;
      saved_state_q <= saved_state_d;
      saved_timer_q <= saved_timer_d;
      prog_q        <= prog_d;
      rinse_cnt_q   <= rinse_cnt_d;
      act_q         <= decode_outputs(state_d);
    end
  end

  assign state      = state_q;
  assign fill_valve = act_q.fill_valve;
  assign drain_pump = act_q.drain_pump;
  assign motor      = act_q.motor;
  assign door_lock  = act_q.door_lock;
  assign done       = act_q.done;
  assign error      = act_q.error;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer with an expected-output scoreboard queue.
module tb_wash_cycle_sequencer;

  localparam logic [3:0] S_IDLE  = 4'd0,  S_FILL  = 4'd1, S_WASH = 4'd2, S_DRAIN = 4'd3;
  localparam logic [3:0] S_RFILL = 4'd4,  S_RINSE = 4'd5, S_RDRN = 4'd6, S_SPIN  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8,  S_PAUSE = 4'd9, S_ERR  = 4'd10;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] outs;
  } exp_t;

  logic       clk = 1'b0;
  logic       power, start, door;
  logic [1:0] prog, water_level;
  logic       fill_valve, drain_pump, door_lock, done, error;
  logic [1:0] motor;
  logic [3:0] state;
  logic [6:0] obs;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  string tag    = "reset";

  wash_cycle_sequencer dut (
    .clkorig     (clk),
    .power       (power),
    .start       (start),
    .door        (door),
    .prog        (prog),
    .water_level (water_level),
    .fill_valve  (fill_valve),
    .drain_pump  (drain_pump),
    .motor       (motor),
    .door_lock   (door_lock),
    .state       (state),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  assign obs = {fill_valve, drain_pump, motor, door_lock, done, error};

  // Expected actuator pattern {fill, pump, motor[1:0], lock, done, error} per state code.
  function automatic logic [6:0] exp_out(input logic [3:0] s);
    case (s)
      S_FILL, S_RFILL: return 7'b1000100;
      S_WASH, S_RINSE: return 7'b0001100;
      S_DRAIN, S_RDRN: return 7'b0100100;
      S_SPIN:          return 7'b0110100;
      S_DONE:          return 7'b0000010;
      S_ERR:           return 7'b0000001;
      default:         return 7'b0000000;
    endcase
  endfunction

  task automatic cyc(input logic [3:0] code);
    exp_t e;
    e.st   = code;
    e.outs = exp_out(code);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    assert (state === e.st)
    else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, e.st);
    end
    checks++;
    assert (obs === e.outs)
    else begin
      errors++;
      $error("FAIL %s outputs: got %b expected %b (state %0d)", tag, obs, e.outs, e.st);
    end
  endtask

  // Quick program from IDLE up to SPIN entry; level rises one step per two cycles.
  task automatic quick_to_spin();
    prog = 2'b00; water_level = 2'd0; start = 1'b1;
    cyc(S_FILL);
    start = 1'b0;
    cyc(S_FILL);
    cyc(S_FILL);
    water_level = 2'd1;
    cyc(S_WASH);
    repeat (19) cyc(S_WASH);
    cyc(S_DRAIN);
    cyc(S_DRAIN);
    water_level = 2'd0;
    cyc(S_RFILL);
    cyc(S_RFILL);
    water_level = 2'd1;
    cyc(S_RINSE);
    repeat (9) cyc(S_RINSE);
    cyc(S_RDRN);
    cyc(S_RDRN);
    water_level = 2'd0;
    cyc(S_SPIN);
  endtask

  initial begin
    power = 1'b0; start = 1'b0; door = 1'b0; prog = 2'b00; water_level = 2'd0;
    cyc(S_IDLE);
    cyc(S_IDLE);
    power = 1'b1;
    cyc(S_IDLE);

    tag = "quick";
    quick_to_spin();
    repeat (11) cyc(S_SPIN);
    cyc(S_DONE);
    start = 1'b1;
    cyc(S_DONE);
    start = 1'b0;
    door = 1'b1;
    cyc(S_IDLE);
    door = 1'b0;

    tag = "heavy";
    prog = 2'b10; water_level = 2'd0; start = 1'b1;
    cyc(S_FILL);
    start = 1'b0; prog = 2'b00;
    water_level = 2'd2;
    cyc(S_FILL);
    water_level = 2'd3;
    cyc(S_WASH);
    repeat (59) cyc(S_WASH);
    cyc(S_DRAIN);
    water_level = 2'd0;
    cyc(S_RFILL);
    water_level = 2'd2;
    cyc(S_RFILL);
    water_level = 2'd3;
    cyc(S_RINSE);
    repeat (9) cyc(S_RINSE);
    cyc(S_RDRN);
    water_level = 2'd0;
    cyc(S_RFILL);
    water_level = 2'd3;
    cyc(S_RINSE);
    repeat (9) cyc(S_RINSE);
    cyc(S_RDRN);
    water_level = 2'd0;
    cyc(S_SPIN);
    repeat (11) cyc(S_SPIN);
    cyc(S_DONE);
    door = 1'b1;
    cyc(S_IDLE);
    door = 1'b0;

    tag = "pause";
    prog = 2'b00; water_level = 2'd1; start = 1'b1;
    cyc(S_FILL);
    start = 1'b0;
    cyc(S_WASH);
    repeat (7) cyc(S_WASH);
    door = 1'b1;
    cyc(S_PAUSE);
    start = 1'b1;
    repeat (3) cyc(S_PAUSE);
    door = 1'b0; start = 1'b0;
    cyc(S_PAUSE);
    start = 1'b1;
    cyc(S_WASH);
    start = 1'b0;
    repeat (12) cyc(S_WASH);
    cyc(S_DRAIN);
    power = 1'b0;
    cyc(S_IDLE);
    power = 1'b1;

    tag = "fill_timeout";
    water_level = 2'd0; start = 1'b1;
    cyc(S_FILL);
    start = 1'b0;
    repeat (7) cyc(S_FILL);
    cyc(S_ERR);
    start = 1'b1;
    cyc(S_ERR);
    start = 1'b0; door = 1'b1;
    cyc(S_ERR);
    door = 1'b0; power = 1'b0;
    cyc(S_IDLE);
    power = 1'b1;

    tag = "spin_reset";
    quick_to_spin();
    repeat (4) cyc(S_SPIN);
    power = 1'b0;
    cyc(S_IDLE);
    power = 1'b1;
    cyc(S_IDLE);
    door = 1'b1; start = 1'b1;
    cyc(S_IDLE);
    cyc(S_IDLE);
    door = 1'b0; start = 1'b0;

    tag = "door_vs_level";
    water_level = 2'd0; start = 1'b1;
    cyc(S_FILL);
    start = 1'b0;
    cyc(S_FILL);
    door = 1'b1; water_level = 2'd1;
    cyc(S_PAUSE);
    door = 1'b0; start = 1'b1;
    cyc(S_FILL);
    start = 1'b0;
    cyc(S_WASH);
    power = 1'b0;
    cyc(S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
